div_seq_ctrl: RTL and testbench
===============================

# div_seq_ctrl

Sequencing controller for the team's 8-bit restoring-division datapath: divisor register D, accumulator A (WIDTH+1 bits, sign in MSB), and dividend/quotient register Q. It accepts a start request and issues one-hot Moore control strobes for load, shift, subtract, restore and quotient-bit write. It loops WIDTH iterations, flags divide-by-zero, and signals completion with a one-cycle done pulse. The controller updates on posedge. The datapath registers capture on negedge, so every strobe is stable half a cycle before it is used.

## Interface
- WIDTH, 8, operand width and iteration count
- CNT_W, 4, iteration counter width; must hold WIDTH
- clk  in  1  clock; state updates on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- d_zero  in  1  datapath status: D == 0
- a_msb  in  1  datapath status: sign bit of A
- ld_d  out  1  load D from operand bus
- ld_q  out  1  load Q with dividend
- clr_a  out  1  clear A
- shift_aq  out  1  shift {A,Q} left one bit
- sub_a  out  1  A <= A - D
- add_a  out  1  A <= A + D (restore)
- wr_q0  out  1  write Q[0]
- q0_val  out  1  value written to Q[0]
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  divide-by-zero; valid with done
- cnt  out  CNT_W  remaining iterations

## Operation
- States: IDLE, LOAD, CHECK, SHIFT, SUB, TEST, RESTORE, SETQ, DONE, ERR.
- All outputs are Moore outputs, decoded from the registered state. Every strobe not listed for a state is 0.
- IDLE: no strobes; busy=0. Go to LOAD if start=1.
- LOAD: ld_d=1, ld_q=1, clr_a=1; cnt <= WIDTH. Go to CHECK.
- CHECK: no strobes. Go to ERR if d_zero=1, else SHIFT.
- SHIFT: shift_aq=1. Go to SUB.
- SUB: sub_a=1. Go to TEST.
- TEST: no strobes. Go to RESTORE if a_msb=1, else SETQ.
- RESTORE: add_a=1, wr_q0=1, q0_val=0; cnt <= cnt-1.
- SETQ: wr_q0=1, q0_val=1; cnt <= cnt-1.
- From RESTORE or SETQ: go to DONE if cnt==1 (before the decrement), else SHIFT.
- DONE: done=1, err=0. Go to IDLE.
- ERR: done=1, err=1; cnt unchanged at WIDTH. Go to IDLE.
- busy=1 in LOAD, CHECK, SHIFT, SUB, TEST, RESTORE, SETQ. busy=0 in IDLE, DONE, ERR.
- start is ignored in every state except IDLE, including DONE. There is no back-to-back acceptance.
- Quotient and remainder are held in Q and A after done until the next LOAD.

## Timing
- Reset values: state=IDLE, cnt=0, all strobes=0, busy=0, done=0, err=0.
- rst has priority over all transitions, including mid-operation. The next cycle is IDLE with all outputs at 0. Datapath contents are don't-care after reset.
- If start is sampled high at posedge N in IDLE:
  - LOAD occupies cycle N+1 and CHECK cycle N+2.
  - Each iteration takes exactly 4 cycles (SHIFT, SUB, TEST, RESTORE/SETQ).
  - DONE occupies cycle N+3+4·WIDTH, which is N+35 for WIDTH=8.
- Divide-by-zero: ERR occupies cycle N+3, with done=1 and err=1 in that cycle.
- Status sampling:
  - d_zero is sampled at the posedge ending CHECK. It reflects D loaded at the negedge inside LOAD.
  - a_msb is sampled at the posedge ending TEST. It reflects the subtraction at the negedge inside SUB.
- cnt decrements WIDTH→0 across the iterations and reads 0 during DONE.

## Test plan
- 100/7 (0x64/0x07), bench datapath model with negedge registers -> done at N+35, err=0, Q=14, A=2; strobes occur in exact state order every cycle.
- Divisor 0, dividend 0x55 -> done=1 and err=1 at N+3; no shift_aq/sub_a ever asserted; busy low from N+3.
- 255/1 -> eight SETQ and zero RESTORE states; Q=0xFF, A=0; add_a never high.
- 5/200 -> eight RESTOREs; Q=0, A=5; q0_val=0 on every wr_q0.
- rst asserted during SUB of iteration 3 -> next cycle IDLE with all outputs 0; a fresh 100/7 then completes correctly at N+35.
- start held high continuously across two operations -> second LOAD begins the cycle after IDLE is re-entered, never during busy or DONE; pulses of start while busy cause no state change.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the restoring-division datapath (D, A, Q registers).
// Strobes are registered Moore outputs so they settle before the datapath's negedge capture.
module div_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             d_zero,
    input  logic             a_msb,
    output logic             ld_d,
    output logic             ld_q,
    output logic             clr_a,
    output logic             shift_aq,
    output logic             sub_a,
    output logic             add_a,
    output logic             wr_q0,
    output logic             q0_val,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_SHIFT,
        S_SUB,
        S_TEST,
        S_RESTORE,
        S_SETQ,
        S_DONE,
        S_ERR
    } state_t;

    typedef struct packed {
        logic ld_d;
        logic ld_q;
        logic clr_a;
        logic shift_aq;
        logic sub_a;
        logic add_a;
        logic wr_q0;
        logic q0_val;
        logic busy;
        logic done;
        logic err;
    } strobes_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    strobes_t         out_q, out_d;

    // Outputs of a state; registering decode(state_d) gives outputs of state_q.
    function automatic strobes_t decode(input state_t s);
        strobes_t o;
        o = '0;
        case (s)
            S_LOAD: begin
                o.ld_d  = 1'b1;
                o.ld_q  = 1'b1;
                o.clr_a = 1'b1;
                o.busy  = 1'b1;
            end
            S_CHECK: o.busy = 1'b1;
            S_SHIFT: begin
                o.shift_aq = 1'b1;
                o.busy     = 1'b1;
            end
            S_SUB: begin
                o.sub_a = 1'b1;
                o.busy  = 1'b1;
            end
            S_TEST: o.busy = 1'b1;
            S_RESTORE: begin
                o.add_a  = 1'b1;
                o.wr_q0  = 1'b1;
                o.q0_val = 1'b0;
                o.busy   = 1'b1;
            end
            S_SETQ: begin
                o.wr_q0  = 1'b1;
                o.q0_val = 1'b1;
                o.busy   = 1'b1;
            end
            S_DONE: o.done = 1'b1;
            S_ERR: begin
                o.done = 1'b1;
                o.err  = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                cnt_d   = CNT_W'(WIDTH);
                state_d = S_CHECK;
            end
            S_CHECK: state_d = d_zero ? S_ERR : S_SHIFT;
            S_SHIFT: state_d = S_SUB;
            S_SUB:   state_d = S_TEST;
            S_TEST:  state_d = a_msb ? S_RESTORE : S_SETQ;
            S_RESTORE, S_SETQ: begin
                // Loop exit looks at the count before this iteration's decrement.
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_SHIFT;
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        out_d = decode(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign ld_d     = out_q.ld_d;
    assign ld_q     = out_q.ld_q;
    assign clr_a    = out_q.clr_a;
    assign shift_aq = out_q.shift_aq;
    assign sub_a    = out_q.sub_a;
    assign add_a    = out_q.add_a;
    assign wr_q0    = out_q.wr_q0;
    assign q0_val   = out_q.q0_val;
    assign busy     = out_q.busy;
    assign done     = out_q.done;
    assign err      = out_q.err;
    assign cnt      = cnt_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: negedge datapath model plus a per-cycle expected-output queue
// derived from integer division of the operands.
module tb_div_seq_ctrl;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic d_zero, a_msb;
    logic ld_d, ld_q, clr_a, shift_aq, sub_a, add_a, wr_q0, q0_val, busy, done, err;
    logic [CNT_W-1:0] cnt;

    logic [7:0] op_d = 8'd0;
    logic [7:0] op_q = 8'd0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .d_zero(d_zero), .a_msb(a_msb),
        .ld_d(ld_d), .ld_q(ld_q), .clr_a(clr_a), .shift_aq(shift_aq), .sub_a(sub_a),
        .add_a(add_a), .wr_q0(wr_q0), .q0_val(q0_val), .busy(busy), .done(done),
        .err(err), .cnt(cnt)
    );

    // Datapath registers capture on negedge.
    logic [7:0] dreg = 8'd0;
    logic [7:0] qreg = 8'd0;
    logic [8:0] areg = 9'd0;
    assign d_zero = (dreg == 8'd0);
    assign a_msb  = areg[8];

    always @(negedge clk) begin
        if (ld_d) dreg <= op_d;
        if (ld_q) qreg <= op_q;
        if (clr_a) areg <= 9'd0;
        if (shift_aq) {areg, qreg} <= {areg[7:0], qreg, 1'b0};
        if (sub_a) areg <= areg - {1'b0, dreg};
        if (add_a) areg <= areg + {1'b0, dreg};
        if (wr_q0) qreg[0] <= q0_val;
    end

    typedef struct packed {
        logic ld_d, ld_q, clr_a, shift_aq, sub_a, add_a, wr_q0, q0_val, busy, done, err;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic ok, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: expected outputs for every cycle, built at acceptance time.
    vec_t       exp_q[$];
    vec_t       cur = '0;
    logic       cur_idle = 1'b1;
    logic       model_ok = 1'b0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic [7:0] exp_quo = 8'd0;
    logic [7:0] exp_rem = 8'd0;

    task automatic build_op(input logic [7:0] dd, input logic [7:0] dv, input logic [CNT_W-1:0] hold);
        vec_t v;
        logic [7:0] quo;
        int r;
        v = '0; v.ld_d = 1; v.ld_q = 1; v.clr_a = 1; v.busy = 1; v.cnt = hold;
        exp_q.push_back(v);
        v = '0; v.busy = 1; v.cnt = CNT_W'(WIDTH);
        exp_q.push_back(v);
        if (dv == 8'd0) begin
            v = '0; v.done = 1; v.err = 1; v.cnt = CNT_W'(WIDTH);
            exp_q.push_back(v);
            return;
        end
        quo = dd / dv;
        exp_quo = quo;
        exp_rem = dd % dv;
        for (int i = 0; i < WIDTH; i++) begin
            r = WIDTH - i;
            v = '0; v.shift_aq = 1; v.busy = 1; v.cnt = CNT_W'(r); exp_q.push_back(v);
            v = '0; v.sub_a = 1;    v.busy = 1; v.cnt = CNT_W'(r); exp_q.push_back(v);
            v = '0;                 v.busy = 1; v.cnt = CNT_W'(r); exp_q.push_back(v);
            v = '0; v.wr_q0 = 1; v.q0_val = quo[WIDTH-1-i]; v.add_a = ~quo[WIDTH-1-i];
            v.busy = 1; v.cnt = CNT_W'(r); exp_q.push_back(v);
        end
        v = '0; v.done = 1; v.cnt = '0;
        exp_q.push_back(v);
    endtask

    always @(posedge clk) begin
        logic [CNT_W-1:0] hold;
        cyc++;
        hold = cur.cnt;
        if (rst) begin
            exp_q.delete();
            cur = '0;
            cur_idle = 1'b1;
            model_ok = 1'b1;
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            cur_idle = 1'b0;
        end else if (cur_idle && start) begin
            build_op(op_q, op_d, hold);
            acc_cyc = cyc;
            cur = exp_q.pop_front();
            cur_idle = 1'b0;
        end else begin
            cur = '0;
            cur.cnt = hold;
            cur_idle = 1'b1;
        end
    end

    // Per-cycle compare and per-operation statistics.
    int n_shift = 0, n_sub = 0, n_add = 0, n_wr0 = 0, n_wr1 = 0, n_done = 0;
    int ld_cyc = 0, done_cyc = 0, last_lat = 0;
    logic last_err = 1'b0;
    logic [7:0] last_q = 8'd0, last_a = 8'd0;

    always @(negedge clk) begin
        vec_t act;
        if (model_ok) begin
            act = {ld_d, ld_q, clr_a, shift_aq, sub_a, add_a, wr_q0, q0_val, busy, done, err, cnt};
            chk($sformatf("outputs@cyc%0d", cyc), act === cur, longint'(act), longint'(cur));
            if (shift_aq) n_shift++;
            if (sub_a) n_sub++;
            if (add_a) n_add++;
            if (wr_q0 && q0_val) n_wr1++;
            if (wr_q0 && !q0_val) n_wr0++;
            if (ld_d) ld_cyc = cyc;
            if (done) begin
                last_lat = cyc - acc_cyc + 1;
                last_err = err;
                last_q = qreg;
                last_a = areg[7:0];
                done_cyc = cyc;
                n_done++;
                if (!err) begin
                    chk("quotient", qreg == exp_quo, longint'(qreg), longint'(exp_quo));
                    chk("remainder", areg == {1'b0, exp_rem}, longint'(areg), longint'(exp_rem));
                end
            end
        end
    end

    task automatic clear_stats();
        n_shift = 0; n_sub = 0; n_add = 0; n_wr0 = 0; n_wr1 = 0;
    endtask

    task automatic wait_done(input int nd0, input string name);
        int t;
        t = 0;
        while (n_done == nd0 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (n_done == nd0) chk({name, "_timeout"}, 1'b0, longint'(t), 0);
    endtask

    task automatic run_op(input logic [7:0] dd, input logic [7:0] dv, input string name);
        int nd0;
        @(posedge clk);
        #2;
        op_q = dd;
        op_d = dv;
        clear_stats();
        nd0 = n_done;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(nd0, name);
    endtask

    initial begin
        int nd0, d1, t;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", {ld_d, ld_q, clr_a, shift_aq, sub_a, add_a, wr_q0, q0_val, busy, done, err, cnt} == '0,
            longint'({ld_d, ld_q, clr_a, shift_aq, sub_a, add_a, wr_q0, q0_val, busy, done, err, cnt}), 0);
        rst = 1'b0;

        run_op(8'd100, 8'd7, "div100_7");
        chk("div100_7_lat", last_lat == 35, last_lat, 35);
        chk("div100_7_err", last_err == 1'b0, last_err, 0);
        chk("div100_7_q", last_q == 8'd14, last_q, 14);
        chk("div100_7_a", last_a == 8'd2, last_a, 2);

        run_op(8'h55, 8'd0, "divzero");
        chk("divzero_lat", last_lat == 3, last_lat, 3);
        chk("divzero_err", last_err == 1'b1, last_err, 1);
        chk("divzero_shift", n_shift == 0, n_shift, 0);
        chk("divzero_sub", n_sub == 0, n_sub, 0);

        run_op(8'd255, 8'd1, "div255_1");
        chk("div255_1_q", last_q == 8'hFF, last_q, 255);
        chk("div255_1_a", last_a == 8'd0, last_a, 0);
        chk("div255_1_add", n_add == 0, n_add, 0);
        chk("div255_1_setq", n_wr1 == 8, n_wr1, 8);

        run_op(8'd5, 8'd200, "div5_200");
        chk("div5_200_q", last_q == 8'd0, last_q, 0);
        chk("div5_200_a", last_a == 8'd5, last_a, 5);
        chk("div5_200_restore", n_wr0 == 8, n_wr0, 8);
        chk("div5_200_q0one", n_wr1 == 0, n_wr1, 0);

        // Reset during the third SUB, then a fresh operation.
        @(posedge clk);
        #2;
        op_q = 8'd100;
        op_d = 8'd7;
        clear_stats();
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        t = 0;
        while (n_sub != 3 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("rst_reach_sub3", n_sub == 3 && sub_a == 1'b1, n_sub, 3);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_outs", {ld_d, ld_q, clr_a, shift_aq, sub_a, add_a, wr_q0, q0_val, busy, done, err, cnt} == '0,
            longint'({ld_d, ld_q, clr_a, shift_aq, sub_a, add_a, wr_q0, q0_val, busy, done, err, cnt}), 0);
        run_op(8'd100, 8'd7, "after_rst");
        chk("after_rst_lat", last_lat == 35, last_lat, 35);
        chk("after_rst_q", last_q == 8'd14, last_q, 14);
        chk("after_rst_a", last_a == 8'd2, last_a, 2);

        // start held high across two operations.
        @(posedge clk);
        #2;
        op_q = 8'd100;
        op_d = 8'd7;
        nd0 = n_done;
        start = 1'b1;
        wait_done(nd0, "held1");
        d1 = done_cyc;
        wait_done(nd0 + 1, "held2");
        start = 1'b0;
        chk("held_gap", ld_cyc - d1 == 2, ld_cyc - d1, 2);
        chk("held_lat", last_lat == 35, last_lat, 35);

        // Random operands with random start pulses while busy.
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #2;
            op_q = 8'($urandom_range(0, 255));
            op_d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            nd0 = n_done;
            start = 1'b1;
            t = 0;
            while (n_done == nd0 && t < 100) begin
                @(posedge clk);
                #2;
                t++;
                if (n_done == nd0) start = 1'($urandom_range(0, 1));
            end
            start = 1'b0;
            if (n_done == nd0) chk("rand_timeout", 1'b0, t, 0);
            else chk("rand_lat", last_lat == (last_err ? 3 : 35), last_lat, last_err ? 3 : 35);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
